// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM memory-stage controller.
// Imported by the controller, its interface and the bench.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  localparam int          SRAM_AW_DEF   = 18;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle between the pipeline and the
// SRAM controller.
interface sram_controller_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en,
    output wr_en,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  rd_en,
    input  wr_en,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );

endinterface

// File: rtl/sram_controller.sv
// Splits a 32-bit load/store into two 16-bit async SRAM accesses,
// low half first, stalling the pipeline until both halves finish.
module sram_controller
  import sram_pkg::*;
#(
  parameter int          PHASE_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF,
  parameter int          SRAM_AW      = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   mem,
  inout  wire  [15:0]        sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int CW = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

  typedef logic [SRAM_AW-2:0] word_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_t         op_q, op_d;
  word_t       word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] offs;
  logic        req;
  logic        last;
  logic        ready_c;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign req  = mem.rd_en | mem.wr_en;
  assign last = (cnt_q == CNT_LAST);
  assign offs = mem.address - BASE_ADDR;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_c   = 1'b0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_addr = '0;
    dq_oe     = 1'b0;
    dq_out    = wdata_q[15:0];

    unique case (state_q)
      IDLE: begin
        ready_c = ~req;
        if (req) begin
          // a simultaneous read and write request resolves to a write
          op_d    = mem.wr_en ? OP_WR : OP_RD;
          word_d  = word_t'(offs >> 2);
          wdata_d = mem.write_data;
          cnt_d   = '0;
          state_d = LOW;
        end
      end
      LOW, HIGH: begin
        sram_addr = {word_q, state_q == HIGH};
        dq_out    = (state_q == HIGH) ? wdata_q[31:16]
                                      : wdata_q[15:0];
        unique case (1'b1)
          op_q == OP_WR: begin
            dq_oe     = 1'b1;
            sram_we_n = last;
          end
          default: begin
            sram_oe_n = 1'b0;
            if (last) begin
              if (state_q == HIGH) rdata_d[31:16] = sram_dq;
              else                 rdata_d[15:0]  = sram_dq;
            end
          end
        endcase
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) state_d = (state_q == HIGH) ? DONE : HIGH;
      end
      DONE: begin
        ready_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign sram_dq = dq_oe ? dq_out : 16'hzzzz;

  assign mem.ready     = ready_c;
  assign mem.read_data = rdata_q;

  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/sram_model.sv
// Behavioural async SRAM: a write commits when we_n rises with the
// address unchanged from the low-we_n cycle. Not synthesised.
module sram_model (
  input  logic        clk,
  inout  wire  [15:0] dq,
  input  logic [17:0] addr,
  input  logic        we_n,
  input  logic        oe_n,
  input  logic        ce_n
);

  logic [15:0] mem [0:63];
  logic        pend;
  logic [17:0] pa;
  logic [15:0] pd;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    pend = 1'b0;
    pa   = '0;
    pd   = '0;
  end

  assign dq = (!ce_n && !oe_n && we_n) ? mem[addr[5:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (pend && we_n && addr == pa) mem[pa[5:0]] <= pd;
    pend <= !we_n;
    pa   <= addr;
    pd   <= dq;
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural SRAM model.
module tb_sram_controller;
  import sram_pkg::*;

  logic        clk;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  sram_controller_if bus ();

  sram_controller #(
    .PHASE_CYCLES(2),
    .BASE_ADDR   (32'd1024),
    .SRAM_AW     (18)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem      (bus),
    .sram_dq  (sram_dq),
    .sram_addr(sram_addr),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n),
    .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  sram_model u_mem (
    .clk (clk),
    .dq  (sram_dq),
    .addr(sram_addr),
    .we_n(sram_we_n),
    .oe_n(sram_oe_n),
    .ce_n(sram_ce_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic        rdy_v  [0:5];
  logic        wen_v  [0:5];
  logic        oen_v  [0:5];
  logic [15:0] dq_v   [0:5];
  logic [17:0] addr_v [0:5];
  logic [31:0] rd_v   [0:5];

  // Cycle 0 is the IDLE cycle in which the request is first seen.
  task automatic do_access(input logic r, input logic w,
                           input logic [31:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    bus.rd_en      = r;
    bus.wr_en      = w;
    bus.address    = a;
    bus.write_data = d;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) begin
        @(negedge clk);
      end
      #1;
      rdy_v[k]  = bus.ready;
      wen_v[k]  = sram_we_n;
      oen_v[k]  = sram_oe_n;
      dq_v[k]   = sram_dq;
      addr_v[k] = sram_addr;
      rd_v[k]   = bus.read_data;
      if (k == 1) begin
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", bus.ready);
    end
    vectors++;
    if ({sram_we_n, sram_oe_n} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_we_oe: got %b want 11", {sram_we_n, sram_oe_n});
    end
    vectors++;
    if (sram_addr !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_addr: got %h want 0", sram_addr);
    end
    vectors++;
    if (bus.read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h want 0", bus.read_data);
    end
    vectors++;
    if ({sram_ce_n, sram_ub_n, sram_lb_n} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ties: got %b want 000",
               {sram_ce_n, sram_ub_n, sram_lb_n});
    end
    rst = 1'b0;
  endtask

  task automatic test_store();
    logic [15:0] exp_dq [0:5];
    logic [17:0] exp_a  [0:5];
    exp_dq = '{16'h0, 16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'h0};
    exp_a  = '{18'd0, 18'd0, 18'd0, 18'd1, 18'd1, 18'd0};
    do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (rdy_v[k] !== (k == 5)) begin
        miscompares++;
        $display("FAIL store_ready c%0d: got %b want %b",
                 k, rdy_v[k], k == 5);
      end
      vectors++;
      if (wen_v[k] !== !(k == 1 || k == 3)) begin
        miscompares++;
        $display("FAIL store_we_n c%0d: got %b want %b",
                 k, wen_v[k], !(k == 1 || k == 3));
      end
      if (k >= 1 && k <= 4) begin
        vectors++;
        if (dq_v[k] !== exp_dq[k] || addr_v[k] !== exp_a[k]
            || oen_v[k] !== 1'b1) begin
          miscompares++;
          $display("FAIL store_bus c%0d: got dq=%h a=%h oe_n=%b want dq=%h a=%h oe_n=1",
                   k, dq_v[k], addr_v[k], oen_v[k], exp_dq[k], exp_a[k]);
        end
      end
    end
    vectors++;
    if (u_mem.mem[0] !== 16'hBEEF || u_mem.mem[1] !== 16'hDEAD) begin
      miscompares++;
      $display("FAIL store_mem: got %h_%h want dead_beef",
               u_mem.mem[1], u_mem.mem[0]);
    end
    vectors++;
    if (rd_v[5] !== 32'h0) begin
      miscompares++;
      $display("FAIL store_rdata_kept: got %h want 0", rd_v[5]);
    end
  endtask

  task automatic test_load();
    do_access(1'b1, 1'b0, 32'd1024, 32'h0);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (rdy_v[k] !== (k == 5) || wen_v[k] !== 1'b1
          || oen_v[k] !== !(k >= 1 && k <= 4)) begin
        miscompares++;
        $display("FAIL load_ctl c%0d: got rdy=%b we_n=%b oe_n=%b",
                 k, rdy_v[k], wen_v[k], oen_v[k]);
      end
    end
    vectors++;
    if (rd_v[5] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL load_rdata: got %h want deadbeef", rd_v[5]);
    end
  endtask

  task automatic test_addr_map();
    do_access(1'b0, 1'b1, 32'd1028, 32'h12345678);
    vectors++;
    if (addr_v[1] !== 18'd2 || addr_v[3] !== 18'd3) begin
      miscompares++;
      $display("FAIL map_addr: got %h/%h want 2/3", addr_v[1], addr_v[3]);
    end
    vectors++;
    if (u_mem.mem[2] !== 16'h5678 || u_mem.mem[3] !== 16'h1234) begin
      miscompares++;
      $display("FAIL map_mem: got %h_%h want 1234_5678",
               u_mem.mem[3], u_mem.mem[2]);
    end
    do_access(1'b1, 1'b0, 32'd1028, 32'h0);
    vectors++;
    if (rd_v[5] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL map_load: got %h want 12345678", rd_v[5]);
    end
    vectors++;
    if (u_mem.mem[0] !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL map_word0: got %h want beef", u_mem.mem[0]);
    end
  endtask

  task automatic test_both();
    do_access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A);
    vectors++;
    if (u_mem.mem[4] !== 16'h5A5A || u_mem.mem[5] !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL both_mem: got %h_%h want a5a5_5a5a",
               u_mem.mem[5], u_mem.mem[4]);
    end
    vectors++;
    if (wen_v[1] !== 1'b0 || oen_v[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL both_ctl: got we_n=%b oe_n=%b want 0/1",
               wen_v[1], oen_v[1]);
    end
    vectors++;
    if (rd_v[5] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL both_rdata: got %h want 12345678", rd_v[5]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.rd_en   = 1'b1;
    bus.wr_en   = 1'b0;
    bus.address = 32'd1024;
    for (int k = 0; k < 12; k++) begin
      if (k != 0) begin
        @(negedge clk);
      end
      #1;
      if (k == 0 || k == 6) begin
        vectors++;
        if (bus.ready !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_ready c%0d: got %b want 0", k, bus.ready);
        end
      end
      if (k == 5 || k == 11) begin
        vectors++;
        if (bus.ready !== 1'b1
            || bus.read_data !== (k == 5 ? 32'hDEADBEEF : 32'h12345678)) begin
          miscompares++;
          $display("FAIL b2b_done c%0d: got rdy=%b data=%h", k,
                   bus.ready, bus.read_data);
        end
      end
      if (k == 7) begin
        vectors++;
        if (sram_addr !== 18'd2) begin
          miscompares++;
          $display("FAIL b2b_addr: got %h want 2", sram_addr);
        end
        bus.rd_en = 1'b0;
      end
      if (k == 2) bus.address = 32'd1032;
      if (k == 5) bus.address = 32'd1028;
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    bus.rd_en      = 1'b0;
    bus.wr_en      = 1'b1;
    bus.address    = 32'd1024;
    bus.write_data = 32'h11112222;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      if (k == 1) bus.wr_en = 1'b0;
    end
    vectors++;
    if (sram_we_n !== 1'b0 || sram_addr !== 18'd1) begin
      miscompares++;
      $display("FAIL rstw_high: got we_n=%b a=%h want 0/1",
               sram_we_n, sram_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (bus.ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1
        || sram_addr !== 18'd0 || bus.read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rstw_state: got rdy=%b we_n=%b oe_n=%b a=%h rd=%h",
               bus.ready, sram_we_n, sram_oe_n, sram_addr, bus.read_data);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (u_mem.mem[0] !== 16'h2222 || u_mem.mem[1] !== 16'hDEAD) begin
      miscompares++;
      $display("FAIL rstw_mem: got %h_%h want dead_2222",
               u_mem.mem[1], u_mem.mem[0]);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    bus.rd_en      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.address    = 32'd1024;
    bus.write_data = 32'h0;
    test_reset();
    test_store();
    test_load();
    test_addr_map();
    test_both();
    test_back_to_back();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
